// File: rtl/regfile_wb_pkg.sv
// Shared widths, defaults and the writeback request type for the register-file
// writeback controller.
package regfile_wb_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned LU_DEPTH     = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer for long-latency unit writebacks; pointers wrap modulo
// Depth, so non-power-of-two depths are supported.
module wb_fifo #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CntW-1:0]  o_count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full   = (count_q == CntW'(Depth));
  assign o_empty  = (count_q == '0);
  assign o_count  = count_q;
  assign o_data   = mem_q[rd_ptr_q];
  assign do_push  = i_push && !o_full;
  assign do_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write port arbiter: in-order pipeline writes take priority over
// buffered long-unit results, with a pending scoreboard and a starvation stall request.
module regfile_wb_ctrl #(
  parameter int unsigned XLEN         = regfile_wb_pkg::XLEN,
  parameter int unsigned LU_DEPTH     = regfile_wb_pkg::LU_DEPTH,
  parameter int unsigned STARVE_LIMIT = regfile_wb_pkg::STARVE_LIMIT
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_stall,
  input  logic                                i_pipe_wren,
  input  logic [regfile_wb_pkg::REG_ADDR_W-1:0] i_pipe_addr,
  input  logic [XLEN-1:0]                     i_pipe_data,
  input  logic                                i_lu_valid,
  input  logic [regfile_wb_pkg::REG_ADDR_W-1:0] i_lu_addr,
  input  logic [XLEN-1:0]                     i_lu_data,
  output logic                                o_lu_ready,
  input  logic                                i_issue_en,
  input  logic [regfile_wb_pkg::REG_ADDR_W-1:0] i_issue_addr,
  output logic                                o_rd_wren,
  output logic [regfile_wb_pkg::REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]                     o_rd_data,
  output logic [31:0]                         o_pending,
  output logic                                o_stall_req
);

  import regfile_wb_pkg::*;

  localparam int unsigned EntryW  = REG_ADDR_W + XLEN;
  localparam int unsigned CntW    = $clog2(LU_DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [EntryW-1:0]     head;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_empty;
  logic                  unused_fifo_full;
  logic                  pipe_win, push, pop;
  logic [31:0]           pending_d;
  logic [StarveW-1:0]    starve_q, starve_d;
  logic                  stall_req_d;

  assign {head_addr, head_data} = head;

  // Ready comes only from the registered occupancy, so a full buffer never
  // accepts on the cycle it is popped.
  assign o_lu_ready = (fifo_count != CntW'(LU_DEPTH));
  assign pipe_win   = !i_stall && i_pipe_wren && (i_pipe_addr != '0);
  assign pop        = !i_stall && !pipe_win && !fifo_empty;
  assign push       = i_lu_valid && o_lu_ready && (i_lu_addr != '0);

  wb_fifo #(
    .Width(EntryW),
    .Depth(LU_DEPTH)
  ) u_wb_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (push),
    .i_pop  (pop),
    .i_data ({i_lu_addr, i_lu_data}),
    .o_data (head),
    .o_full (unused_fifo_full),
    .o_empty(fifo_empty),
    .o_count(fifo_count)
  );

  always_comb begin
    pending_d = o_pending;
    if (pop) begin
      pending_d[head_addr] = 1'b0;
    end
    if (i_issue_en) begin
      pending_d[i_issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    starve_d    = starve_q;
    stall_req_d = 1'b0;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (pipe_win) begin
      if (starve_q == StarveW'(STARVE_LIMIT - 1)) begin
        starve_d    = '0;
        stall_req_d = 1'b1;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_wren   <= 1'b0;
      o_rd_addr   <= '0;
      o_rd_data   <= '0;
      o_pending   <= '0;
      o_stall_req <= 1'b0;
      starve_q    <= '0;
    end else begin
      if (!i_stall) begin
        if (pipe_win) begin
          o_rd_wren <= 1'b1;
          o_rd_addr <= i_pipe_addr;
          o_rd_data <= i_pipe_data;
        end else if (!fifo_empty) begin
          o_rd_wren <= 1'b1;
          o_rd_addr <= head_addr;
          o_rd_data <= head_data;
        end else begin
          o_rd_wren <= 1'b0;
        end
      end
      o_pending   <= pending_d;
      o_stall_req <= stall_req_d;
      starve_q    <= starve_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized and directed bench for regfile_wb_ctrl with a queue-based reference
// model and a decoupled output monitor.
module tb_regfile_wb_ctrl;
  import regfile_wb_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_stall, i_pipe_wren, i_lu_valid, i_issue_en;
  logic [4:0]  i_pipe_addr, i_lu_addr, i_issue_addr;
  logic [31:0] i_pipe_data, i_lu_data;
  logic        o_lu_ready, o_rd_wren, o_stall_req;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data, o_pending;

  always #5 i_clk = ~i_clk;

  regfile_wb_ctrl #(
    .XLEN(XLEN),
    .LU_DEPTH(LU_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_stall     (i_stall),
    .i_pipe_wren (i_pipe_wren),
    .i_pipe_addr (i_pipe_addr),
    .i_pipe_data (i_pipe_data),
    .i_lu_valid  (i_lu_valid),
    .i_lu_addr   (i_lu_addr),
    .i_lu_data   (i_lu_data),
    .o_lu_ready  (o_lu_ready),
    .i_issue_en  (i_issue_en),
    .i_issue_addr(i_issue_addr),
    .o_rd_wren   (o_rd_wren),
    .o_rd_addr   (o_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_pending   (o_pending),
    .o_stall_req (o_stall_req)
  );

  // Reference model state: buffered results, expected writes, scoreboard, starvation.
  wb_req_t     buf_m[$];
  wb_req_t     exp_q[$];
  logic [31:0] pend_m;
  int          starve_m;
  logic        sreq_m;
  int          checks, passed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge: check model-visible state, drive inputs, advance the model.
  task automatic cycle(input logic stall, input logic pw, input logic [4:0] pa,
                       input logic [31:0] pd, input logic lv, input logic [4:0] la,
                       input logic [31:0] ld, input logic ie, input logic [4:0] ia);
    bit          ready, was_empty, sreq_n;
    logic [31:0] clr;
    wb_req_t     h;
    chk("lu_ready", {63'd0, o_lu_ready}, {63'd0, buf_m.size() < LU_DEPTH});
    chk("pending", {32'd0, o_pending}, {32'd0, pend_m});
    chk("stall_req", {63'd0, o_stall_req}, {63'd0, sreq_m});
    i_stall = stall; i_pipe_wren = pw; i_pipe_addr = pa; i_pipe_data = pd;
    i_lu_valid = lv; i_lu_addr = la; i_lu_data = ld; i_issue_en = ie; i_issue_addr = ia;
    ready     = buf_m.size() < LU_DEPTH;
    was_empty = buf_m.size() == 0;
    clr       = '0;
    sreq_n    = 1'b0;
    if (!stall) begin
      if (pw && pa != 0) begin
        exp_q.push_back('{addr: pa, data: pd});
        if (was_empty) starve_m = 0;
        else begin
          starve_m++;
          if (starve_m == STARVE_LIMIT) begin
            sreq_n   = 1'b1;
            starve_m = 0;
          end
        end
      end else if (!was_empty) begin
        h = buf_m.pop_front();
        exp_q.push_back(h);
        clr[h.addr] = 1'b1;
        starve_m    = 0;
      end else begin
        starve_m = 0;
      end
    end else if (was_empty) begin
      starve_m = 0;
    end
    if (lv && ready && la != 0) buf_m.push_back('{addr: la, data: ld});
    pend_m = pend_m & ~clr;
    if (ie && ia != 0) pend_m[ia] = 1'b1;
    sreq_m = sreq_n;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_stall = 0; i_pipe_wren = 0; i_lu_valid = 0; i_issue_en = 0;
    #1;
    chk("rst_wren", {63'd0, o_rd_wren}, 64'd0);
    chk("rst_addr", {59'd0, o_rd_addr}, 64'd0);
    chk("rst_data", {32'd0, o_rd_data}, 64'd0);
    chk("rst_pending", {32'd0, o_pending}, 64'd0);
    chk("rst_ready", {63'd0, o_lu_ready}, 64'd1);
    chk("rst_stall_req", {63'd0, o_stall_req}, 64'd0);
    buf_m.delete(); exp_q.delete();
    pend_m = '0; starve_m = 0; sreq_m = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Monitor: a new output write is presented after every non-stalled edge.
  initial begin
    logic        lw;
    logic [4:0]  la;
    logic [31:0] ld;
    wb_req_t     e;
    lw = 0; la = 0; ld = 0;
    forever begin
      @(posedge i_clk); #1;
      if (i_rst) begin
        lw = 0; la = 0; ld = 0;
        continue;
      end
      if (i_stall) begin
        chk("hold", {27'd0, lw, la, ld}, {27'd0, o_rd_wren, o_rd_addr, o_rd_data});
      end else begin
        chk("rd_wren", {63'd0, o_rd_wren}, {63'd0, exp_q.size() != 0});
        if (o_rd_wren && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rd_addr", {59'd0, o_rd_addr}, {59'd0, e.addr});
          chk("rd_data", {32'd0, o_rd_data}, {32'd0, e.data});
        end
      end
      if (o_rd_wren) chk("rd_not_x0", {63'd0, o_rd_addr != 0}, 64'd1);
      lw = o_rd_wren; la = o_rd_addr; ld = o_rd_data;
    end
  end

  initial begin
    checks = 0; passed = 0;
    i_rst = 1'b1; i_stall = 0; i_pipe_wren = 0; i_pipe_addr = 0; i_pipe_data = 0;
    i_lu_valid = 0; i_lu_addr = 0; i_lu_data = 0; i_issue_en = 0; i_issue_addr = 0;
    @(negedge i_clk);
    do_reset();

    // Pipeline write lands one cycle later.
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0);
    chk("t_pipe_wren", {63'd0, o_rd_wren}, 64'd1);
    chk("t_pipe_addr", {59'd0, o_rd_addr}, 64'd5);
    chk("t_pipe_data", {32'd0, o_rd_data}, 64'hDEADBEEF);
    idle(2);

    // Scoreboard bit held until the long-unit write two cycles after the result.
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7);
    chk("t_pend7_set", {63'd0, o_pending[7]}, 64'd1);
    cycle(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h1234, 0, 5'd0);
    chk("t_pend7_hold", {63'd0, o_pending[7]}, 64'd1);
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
    chk("t_lu_addr", {59'd0, o_rd_addr}, 64'd7);
    chk("t_lu_data", {32'd0, o_rd_data}, 64'h1234);
    chk("t_pend7_clr", {63'd0, o_pending[7]}, 64'd0);
    idle(1);

    // Pipeline hogs the port: buffer fills, then a starvation pulse.
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 5'(10 + i), $urandom, (i < 3), 5'(20 + i), $urandom, 0, 5'd0);
      if (i == 1) chk("t_ready_low", {63'd0, o_lu_ready}, 64'd0);
      if (i == 4) chk("t_starve_pulse", {63'd0, o_stall_req}, 64'd1);
    end

    // Stall holds the x3 write and keeps the buffered entries in place.
    cycle(0, 1, 5'd3, 32'hC0FFEE03, 0, 5'd0, 32'd0, 0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 5'd9, 32'h99, 0, 5'd0, 32'd0, 0, 5'd0);
      chk("t_stall_addr", {59'd0, o_rd_addr}, 64'd3);
      chk("t_stall_data", {32'd0, o_rd_data}, 64'hC0FFEE03);
    end
    chk("t_stall_nopop", {63'd0, o_lu_ready}, 64'd0);
    idle(4);

    // Issue and clear of the same register in one cycle leave the bit set.
    cycle(0, 1, 5'd4, 32'h44, 1, 5'd9, 32'h9999, 1, 5'd9);
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9);
    chk("t_set_wins", {63'd0, o_pending[9]}, 64'd1);
    idle(2);

    // Reset with two buffered entries drops everything.
    cycle(0, 1, 5'd6, 32'h66, 1, 5'd11, 32'hB, 1, 5'd11);
    cycle(0, 1, 5'd6, 32'h67, 1, 5'd12, 32'hC, 1, 5'd12);
    do_reset();
    idle(4);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle($urandom_range(0, 4) == 0, 1'($urandom), 5'($urandom_range(0, 31)),
                 $urandom, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 7)));
    end
    idle(LU_DEPTH + 3);
    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
